sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// - Shares the single SDRAM controller command port between three requesters:
//   video fetch (CRTC character/colour reads), Z80 CPU (read/write) and the ROM/tape image loader (write-only).
// - Sits between the core glue and the SDRAM controller driving ramCk..ramA.
// - Allows one outstanding transaction at a time. Read data is latched, and completion is returned to the granted requester only.
// PARAMETERS
// - AW       22    address width, shared by all ports (word = byte)
// - DW       8     data width
// - TMO      255   mem_ack watchdog limit, in clock cycles; must be >= 2
// PORTS
// - clock      in   1    system clock (35.468 MHz)
// - power      in   1    asynchronous reset, active-low
// - v_req      in   1    video read request; level, held until v_ack
// - v_addr     in   AW   video read address
// - v_q        out  DW   video read data; valid in the v_ack cycle, held until the next video completion
// - v_ack      out  1    video completion pulse, 1 cycle
// - c_req      in   1    CPU request; level, held until c_ack
// - c_we       in   1    CPU write (1) / read (0)
// - c_addr     in   AW   CPU address
// - c_d        in   DW   CPU write data
// - c_q        out  DW   CPU read data; valid in the c_ack cycle, held until the next CPU read completion
// - c_ack      out  1    CPU completion pulse, 1 cycle
// - l_req      in   1    loader write request; level, held until l_ack
// - l_addr     in   AW   loader address
// - l_d        in   DW   loader write data
// - l_ack      out  1    loader completion pulse, 1 cycle
// - mem_req    out  1    request to the SDRAM controller; held until mem_ack
// - mem_we     out  1    write strobe qualifier
// - mem_addr   out  AW   address, registered at grant
// - mem_d      out  DW   write data, registered at grant
// - mem_q      in   DW   read data; valid when mem_ack = 1
// - mem_ack    in   1    controller completion; 1-cycle pulse
// - busy       out  1    1 while a transaction is outstanding
// - tmo_err    out  1    sticky watchdog flag; cleared only by reset
// BEHAVIOUR
// - Reset (power = 0, asynchronous):
//   - all outputs 0; state = IDLE; rr = 0 (CPU favoured); watchdog = 0.
//   - A transaction in flight is abandoned: no ack is issued after reset is released.
// - Priority: video > {CPU, loader}. CPU and loader alternate round-robin.
//   - Bit rr is updated on each completed CPU or loader grant: rr=0 means CPU wins a tie; rr=1 means loader wins.
// - FSM IDLE:
//   - If any request is high at edge n: latch the winner into gnt, register mem_addr/mem_we/mem_d, and go to WAIT.
//   - mem_req = 1 from cycle n+1.
//   - Video grants force mem_we = 0. Loader grants force mem_we = 1.
// - FSM WAIT:
//   - mem_req held high with stable mem_addr/mem_we/mem_d.
//   - On mem_ack at edge m: drop mem_req, latch mem_q into the granted q register if it was a read, pulse that requester's ack during cycle m+1, and return to IDLE.
//   - A new grant can be evaluated at edge m+1. Minimum occupancy is 3 cycles per transaction.
// - Watchdog:
//   - Counts cycles spent in WAIT.
//   - On reaching TMO with no mem_ack: drop mem_req, set tmo_err, pulse the granted ack with q unchanged, and return to IDLE.
// - Boundary conditions:
//   - Requester drops req while granted: the transaction still completes and the ack still pulses.
//   - mem_ack while IDLE: ignored.
//   - Requests arriving while in WAIT: queued by level, not by edge.
//   - Same requester re-asserts req in its ack cycle: treated as a new request.
//   - All three requests high: video is granted; the CPU/loader tie is resolved by rr.
//   - Continuous video requests: CPU and loader starve. Video fetch duty must leave gaps (guaranteed by CRTC timing).
//   - Address and data widths pass through unchanged; no arithmetic is performed on addresses.
// CONFIGURATION
// - Macro ARB_LOADER_EN:
//   - Defined: loader port is live, as described above.
//   - Undefined: l_req is ignored; l_ack is tied to 0; rr is removed and the CPU is always the second priority.
//     Port list is unchanged so the glue connection stays the same.
// TESTING
// - Single CPU read: c_req=1, c_we=0, c_addr=0x00123; mem_ack one cycle later with mem_q=0xA5
//   -> mem_req rises 1 cycle after c_req; c_ack pulses 1 cycle; c_q=0xA5.
// - v_req, c_req and l_req all raised in the same cycle (ARB_LOADER_EN defined)
//   -> grant order video, CPU, loader; then with repeated requests CPU/loader alternate.
// - Loader write l_addr=0x3FFFFF, l_d=0x5A
//   -> mem_we=1, mem_addr=0x3FFFFF, mem_d=0x5A stable until mem_ack; l_ack pulses once.
// - No mem_ack for TMO=255 cycles
//   -> at cycle 255 of WAIT: mem_req=0, tmo_err=1, granted ack pulses; next request is served normally.
// - power pulled low during WAIT, then released
//   -> all outputs 0 immediately; no stray ack; rr=0.
// - ARB_LOADER_EN undefined: l_req held high
//   -> never granted; l_ack stays 0; CPU is served every time video is idle.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester, controller and status signals around sdram_port_arbiter.
// master = core glue / controller side, slave = arbiter side.
interface sdram_port_arbiter_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 8
);
  // Video fetch port (read-only)
  logic          v_req;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_q;
  logic          v_ack;

  // CPU port
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_d;
  logic [DW-1:0] c_q;
  logic          c_ack;

  // Loader port (write-only)
  logic          l_req;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_d;
  logic          l_ack;

  // SDRAM controller command port
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic          mem_ack;

  // Status
  logic          busy;
  logic          tmo_err;

  modport master (
    output v_req, v_addr,
    output c_req, c_we, c_addr, c_d,
    output l_req, l_addr, l_d,
    output mem_q, mem_ack,
    input  v_q, v_ack, c_q, c_ack, l_ack,
    input  mem_req, mem_we, mem_addr, mem_d,
    input  busy, tmo_err
  );

  modport slave (
    input  v_req, v_addr,
    input  c_req, c_we, c_addr, c_d,
    input  l_req, l_addr, l_d,
    input  mem_q, mem_ack,
    output v_q, v_ack, c_q, c_ack, l_ack,
    output mem_req, mem_we, mem_addr, mem_d,
    output busy, tmo_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Single-outstanding arbiter sharing the SDRAM command port among video, CPU and loader.
// Optional macro ARB_LOADER_EN enables the loader port and the CPU/loader round-robin bit.
module sdram_port_arbiter #(
  parameter int unsigned AW  = 22,
  parameter int unsigned DW  = 8,
  parameter int unsigned TMO = 255
) (
  input  logic                clock,
  input  logic                power,
  sdram_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(TMO + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_LDR} gnt_t;

  state_t        r_state,    w_state;
  gnt_t          r_gnt,      w_gnt;
  logic [CW-1:0] r_cnt,      w_cnt;
  logic          r_mem_req,  w_mem_req;
  logic          r_mem_we,   w_mem_we;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [DW-1:0] r_mem_d,    w_mem_d;
  logic [DW-1:0] r_v_q,      w_v_q;
  logic [DW-1:0] r_c_q,      w_c_q;
  logic          r_v_ack,    w_v_ack;
  logic          r_c_ack,    w_c_ack;
  logic          r_l_ack,    w_l_ack;
  logic          r_busy,     w_busy;
  logic          r_tmo_err,  w_tmo_err;
  logic          w_fin;
  logic          w_c_win;
  logic          w_l_win;

`ifdef ARB_LOADER_EN
  logic          r_rr,       w_rr;

  // rr = 0: CPU wins a CPU/loader tie; rr = 1: loader wins
  assign w_c_win = bus.c_req & ~(bus.l_req & r_rr);
  assign w_l_win = bus.l_req & ~(bus.c_req & ~r_rr);
`else
  wire           w_unused_l_req = bus.l_req;

  assign w_c_win = bus.c_req;
  assign w_l_win = 1'b0;
`endif

  // Next-state and next-register values
  always_comb begin
    w_state    = r_state;
    w_gnt      = r_gnt;
    w_cnt      = r_cnt;
    w_mem_req  = r_mem_req;
    w_mem_we   = r_mem_we;
    w_mem_addr = r_mem_addr;
    w_mem_d    = r_mem_d;
    w_v_q      = r_v_q;
    w_c_q      = r_c_q;
    w_v_ack    = 1'b0;
    w_c_ack    = 1'b0;
    w_l_ack    = 1'b0;
    w_busy     = r_busy;
    w_tmo_err  = r_tmo_err;
    w_fin      = 1'b0;
`ifdef ARB_LOADER_EN
    w_rr       = r_rr;
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (bus.v_req || w_c_win || w_l_win) begin
          w_state   = S_WAIT;
          w_mem_req = 1'b1;
          w_busy    = 1'b1;
          if (bus.v_req) begin
            w_gnt      = G_VID;
            w_mem_we   = 1'b0;
            w_mem_addr = bus.v_addr;
            w_mem_d    = '0;
          end else if (w_c_win) begin
            w_gnt      = G_CPU;
            w_mem_we   = bus.c_we;
            w_mem_addr = bus.c_addr;
            w_mem_d    = bus.c_d;
          end else begin
            w_gnt      = G_LDR;
            w_mem_we   = 1'b1;
            w_mem_addr = bus.l_addr;
            w_mem_d    = bus.l_d;
          end
        end
      end

      S_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle
        if (bus.mem_ack) begin
          w_fin = 1'b1;
          if (r_gnt == G_VID) begin
            w_v_q = bus.mem_q;
          end
          if ((r_gnt == G_CPU) && !r_mem_we) begin
            w_c_q = bus.mem_q;
          end
        end else if (r_cnt == CW'(TMO - 1)) begin
          w_fin     = 1'b1;
          w_tmo_err = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end

        if (w_fin) begin
          w_state   = S_IDLE;
          w_mem_req = 1'b0;
          w_busy    = 1'b0;
          w_gnt     = G_NONE;
          w_v_ack   = (r_gnt == G_VID);
          w_c_ack   = (r_gnt == G_CPU);
          w_l_ack   = (r_gnt == G_LDR);
`ifdef ARB_LOADER_EN
          if (r_gnt == G_CPU) begin
            w_rr = 1'b1;
          end else if (r_gnt == G_LDR) begin
            w_rr = 1'b0;
          end
`endif
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clock or negedge power) begin
    if (!power) begin
      r_state    <= S_IDLE;
      r_gnt      <= G_NONE;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
      r_v_q      <= '0;
      r_c_q      <= '0;
      r_v_ack    <= 1'b0;
      r_c_ack    <= 1'b0;
      r_l_ack    <= 1'b0;
      r_busy     <= 1'b0;
      r_tmo_err  <= 1'b0;
`ifdef ARB_LOADER_EN
      r_rr       <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_gnt      <= w_gnt;
      r_cnt      <= w_cnt;
      r_mem_req  <= w_mem_req;
      r_mem_we   <= w_mem_we;
      r_mem_addr <= w_mem_addr;
      r_mem_d    <= w_mem_d;
      r_v_q      <= w_v_q;
      r_c_q      <= w_c_q;
      r_v_ack    <= w_v_ack;
      r_c_ack    <= w_c_ack;
      r_l_ack    <= w_l_ack;
      r_busy     <= w_busy;
      r_tmo_err  <= w_tmo_err;
`ifdef ARB_LOADER_EN
      r_rr       <= w_rr;
`endif
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_d    = r_mem_d;
  assign bus.v_q      = r_v_q;
  assign bus.v_ack    = r_v_ack;
  assign bus.c_q      = r_c_q;
  assign bus.c_ack    = r_c_ack;
  assign bus.busy     = r_busy;
  assign bus.tmo_err  = r_tmo_err;
`ifdef ARB_LOADER_EN
  assign bus.l_ack    = r_l_ack;
`else
  wire   w_unused_l_ack = r_l_ack;
  assign bus.l_ack    = 1'b0;
`endif

endmodule
